// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the multi-cycle MIPS-subset control path.
// Holds the FSM state encoding, the decoder's instruction-type codes,
// the ALU operation codes, the ALU B-operand select codes and the
// funct/opcode constants the controller needs to tell instructions apart.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    // Instruction-type codes produced by the upstream opcode decoder
    localparam logic [3:0] TYPE_UNSUP = 4'd0;
    localparam logic [3:0] TYPE_RTYPE = 4'd1;
    localparam logic [3:0] TYPE_IMM   = 4'd2;
    localparam logic [3:0] TYPE_BEQ   = 4'd3;
    localparam logic [3:0] TYPE_LW    = 4'd4;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    // ALU B-operand select codes
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    // Supported R-type funct values and type-2 opcodes
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_ORI     = 6'h0D;

endpackage

// File: rtl/mc_control_if.sv
// mc_control_if: bundle between the multi-cycle controller and the datapath.
// Ports (by modport):
//   slave  (controller): takes instr, instr_type, mem_ready, alu_zero;
//                        drives every enable/select, state, trap, retired.
//   master (datapath):   the mirror image.
// Parameter CNT_W sets the width of the retired-instruction counter.
interface mc_control_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr;
    logic [3:0]       instr_type;
    logic             mem_ready;
    logic             alu_zero;

    logic             pc_we;
    logic             pc_src;
    logic             ir_we;
    logic             mem_rd;
    logic             i_or_d;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic             ext_op;
    logic [2:0]       alu_ctrl;
    logic             reg_we;
    logic             reg_dst;
    logic             mem_to_reg;
    logic [2:0]       state;
    logic             trap;
    logic [CNT_W-1:0] retired;

    modport slave (
        input  instr, instr_type, mem_ready, alu_zero,
        output pc_we, pc_src, ir_we, mem_rd, i_or_d, alu_src_a, alu_src_b,
               ext_op, alu_ctrl, reg_we, reg_dst, mem_to_reg, state, trap,
               retired
    );

    modport master (
        output instr, instr_type, mem_ready, alu_zero,
        input  pc_we, pc_src, ir_we, mem_rd, i_or_d, alu_src_a, alu_src_b,
               ext_op, alu_ctrl, reg_we, reg_dst, mem_to_reg, state, trap,
               retired
    );

endinterface

// File: rtl/mc_control_alu_ctrl_dec.sv
// alu_ctrl_dec: combinational ALU-operation decoder for the controller.
// Ports:
//   itype, opcode, funct : instruction fields (live in DECODE, latched later)
//   state                : current controller state
//   alu_ctrl             : ALU operation for this cycle
//   funct_illegal        : R-type whose funct is neither addu nor subu
module alu_ctrl_dec
    import cpu_pkg::*;
(
    input  logic [3:0] itype,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  state_t     state,
    output logic [2:0] alu_ctrl,
    output logic       funct_illegal
);

    // Only EXEC uses a non-ADD operation; FETCH computes PC+4 and
    // DECODE computes the branch target, both with ADD.
    always_comb begin
        alu_ctrl      = ALU_ADD;
        funct_illegal = (itype == TYPE_RTYPE) &&
                        (funct != FUNCT_ADDU) && (funct != FUNCT_SUBU);
        if (state == ST_EXEC) begin
            case (itype)
                TYPE_RTYPE: alu_ctrl = (funct == FUNCT_SUBU) ? ALU_SUB : ALU_ADD;
                TYPE_IMM:   alu_ctrl = (opcode == OP_LUI) ? ALU_LUI : ALU_OR;
                TYPE_BEQ:   alu_ctrl = ALU_SUB;
                default:    alu_ctrl = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle control FSM for the MIPS-subset CPU.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives all datapath enables and
// selects, counts retired instructions and parks in a sticky TRAP state
// on unsupported encodings.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high
//   bus   : mc_control_if slave modport (instruction inputs, mem_ready,
//           alu_zero in; enables, selects, state, trap, retired out)
module mc_control
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    mc_control_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       type_q;
    logic [5:0]       opcode_q;
    logic [5:0]       funct_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire_inc;

    logic [3:0]       dec_type;
    logic [5:0]       dec_opcode;
    logic [5:0]       dec_funct;
    logic [2:0]       alu_ctrl_c;
    logic             funct_illegal;

    logic             pc_we_c;
    logic             pc_src_c;
    logic             ir_we_c;
    logic             mem_rd_c;
    logic             i_or_d_c;
    logic             alu_src_a_c;
    logic [1:0]       alu_src_b_c;
    logic             ext_op_c;
    logic             reg_we_c;
    logic             reg_dst_c;
    logic             mem_to_reg_c;

    logic             unused_instr_bits;
    assign unused_instr_bits = ^bus.instr[25:6];

    // In DECODE the latches are being loaded on this very edge, so the
    // legality decision has to look at the live IR fields; every later
    // state works only from the latched copies.
    always_comb begin
        if (state_q == ST_DECODE) begin
            dec_type   = bus.instr_type;
            dec_opcode = bus.instr[31:26];
            dec_funct  = bus.instr[5:0];
        end else begin
            dec_type   = type_q;
            dec_opcode = opcode_q;
            dec_funct  = funct_q;
        end
    end

    alu_ctrl_dec u_alu_ctrl_dec (
        .itype         (dec_type),
        .opcode        (dec_opcode),
        .funct         (dec_funct),
        .state         (state_q),
        .alu_ctrl      (alu_ctrl_c),
        .funct_illegal (funct_illegal)
    );

    // State register, instruction-field latches and retired counter.
    // The counter bumps on the same edge that leaves the final state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            type_q    <= '0;
            opcode_q  <= '0;
            funct_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                type_q   <= bus.instr_type;
                opcode_q <= bus.instr[31:26];
                funct_q  <= bus.instr[5:0];
            end
            if (retire_inc) begin
                retired_q <= retired_q + CNT_ONE;
            end
        end
    end

    // Next-state and output decode. Everything is Moore except pc_we/ir_we,
    // which follow mem_ready in FETCH and alu_zero for a beq in EXEC.
    always_comb begin
        state_d      = state_q;
        retire_inc   = 1'b0;
        pc_we_c      = 1'b0;
        pc_src_c     = 1'b0;
        ir_we_c      = 1'b0;
        mem_rd_c     = 1'b0;
        i_or_d_c     = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = SRCB_REG;
        ext_op_c     = 1'b0;
        reg_we_c     = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_rd_c    = 1'b1;
                alu_src_b_c = SRCB_FOUR;
                pc_we_c     = bus.mem_ready;
                ir_we_c     = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                alu_src_b_c = SRCB_BRANCH;
                ext_op_c    = 1'b1;
                // Codes above lw are never produced by the decoder; they
                // are treated as unsupported rather than guessed at.
                if ((dec_type == TYPE_UNSUP) || (dec_type > TYPE_LW) ||
                    funct_illegal) begin
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                alu_src_a_c = 1'b1;
                case (type_q)
                    TYPE_RTYPE: begin
                        alu_src_b_c = SRCB_REG;
                        state_d     = ST_WB;
                    end
                    TYPE_IMM: begin
                        alu_src_b_c = SRCB_IMM;
                        ext_op_c    = 1'b0;
                        state_d     = ST_WB;
                    end
                    TYPE_BEQ: begin
                        alu_src_b_c = SRCB_REG;
                        pc_src_c    = 1'b1;
                        pc_we_c     = bus.alu_zero;
                        state_d     = ST_FETCH;
                        retire_inc  = 1'b1;
                    end
                    TYPE_LW: begin
                        alu_src_b_c = SRCB_IMM;
                        ext_op_c    = 1'b1;
                        state_d     = ST_MEM;
                    end
                    default: begin
                        alu_src_a_c = 1'b0;
                        state_d     = ST_TRAP;
                    end
                endcase
            end

            ST_MEM: begin
                mem_rd_c = 1'b1;
                i_or_d_c = 1'b1;
                if (bus.mem_ready) begin
                    state_d = ST_WB;
                end
            end

            ST_WB: begin
                reg_we_c     = 1'b1;
                reg_dst_c    = (type_q == TYPE_RTYPE);
                mem_to_reg_c = (type_q == TYPE_LW);
                state_d      = ST_FETCH;
                retire_inc   = 1'b1;
            end

            ST_TRAP: begin
                state_d = ST_TRAP;
            end

            // Unused encodings 6 and 7 recover to FETCH
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Write enables and the read strobe are held off while reset is high so
    // an abandoned instruction can never issue a partial write.
    assign bus.pc_we      = pc_we_c  & ~reset;
    assign bus.ir_we      = ir_we_c  & ~reset;
    assign bus.reg_we     = reg_we_c & ~reset;
    assign bus.mem_rd     = mem_rd_c & ~reset;
    assign bus.pc_src     = pc_src_c;
    assign bus.i_or_d     = i_or_d_c;
    assign bus.alu_src_a  = alu_src_a_c;
    assign bus.alu_src_b  = alu_src_b_c;
    assign bus.ext_op     = ext_op_c;
    assign bus.alu_ctrl   = alu_ctrl_c;
    assign bus.reg_dst    = reg_dst_c;
    assign bus.mem_to_reg = mem_to_reg_c;
    assign bus.state      = state_q;
    assign bus.trap       = (state_q == ST_TRAP);
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: self-checking bench for mc_control.
// Each instruction is expanded into an expected per-cycle trace (phase,
// control word, mem_ready to drive, whether an instruction retires at the
// end of the cycle) straight from the instruction's behaviour, then the
// trace is played against the DUT and every cycle is compared.
module tb_mc_control;

    localparam int CNT_W = 32;

    // Control-word field masks (bench-side packing of the DUT outputs)
    localparam logic [15:0] PC_WE    = 16'h8000;
    localparam logic [15:0] PC_SRC   = 16'h4000;
    localparam logic [15:0] IR_WE    = 16'h2000;
    localparam logic [15:0] MEM_RD   = 16'h1000;
    localparam logic [15:0] I_OR_D   = 16'h0800;
    localparam logic [15:0] SRC_A    = 16'h0400;
    localparam logic [15:0] B_FOUR   = 16'h0100;
    localparam logic [15:0] B_IMM    = 16'h0200;
    localparam logic [15:0] B_BR     = 16'h0300;
    localparam logic [15:0] EXT      = 16'h0080;
    localparam logic [15:0] A_SUB    = 16'h0010;
    localparam logic [15:0] A_OR     = 16'h0020;
    localparam logic [15:0] A_LUI    = 16'h0030;
    localparam logic [15:0] REG_WE   = 16'h0008;
    localparam logic [15:0] REG_DST  = 16'h0004;
    localparam logic [15:0] M2R      = 16'h0002;
    localparam logic [15:0] TRAP     = 16'h0001;

    logic clk = 1'b0;
    logic reset;

    mc_control_if #(.CNT_W(CNT_W)) bus ();

    mc_control #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  st;
        logic [15:0] word;
        logic        mr;
        logic        retire;
        logic        scramble;
    } step_t;

    step_t       trace[$];
    int          assertCount = 0;
    int          failCount   = 0;
    logic [31:0] expRetired  = '0;

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic rndBit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [15:0] obsWord();
        return {bus.pc_we, bus.pc_src, bus.ir_we, bus.mem_rd, bus.i_or_d,
                bus.alu_src_a, bus.alu_src_b, bus.ext_op, bus.alu_ctrl,
                bus.reg_we, bus.reg_dst, bus.mem_to_reg, bus.trap};
    endfunction

    task automatic pushStep(input logic [2:0] st, input logic [15:0] word,
                            input logic mr, input logic retire, input logic scramble);
        step_t s;
        s.st = st; s.word = word; s.mr = mr; s.retire = retire; s.scramble = scramble;
        trace.push_back(s);
    endtask

    // Expected behaviour of one instruction: fetch (with stalls), decode,
    // then either ten trap cycles or the type-specific tail.
    task automatic buildTrace(input logic [31:0] ins, input logic [3:0] ity,
                              input logic az, input int fStall, input int mStall);
        logic [5:0] op;
        logic [5:0] fn;
        logic       legal;
        op = ins[31:26];
        fn = ins[5:0];
        trace.delete();
        for (int i = 0; i < fStall; i++)
            pushStep(3'd0, MEM_RD | B_FOUR, 1'b0, 1'b0, 1'b0);
        pushStep(3'd0, PC_WE | IR_WE | MEM_RD | B_FOUR, 1'b1, 1'b0, 1'b0);
        pushStep(3'd1, B_BR | EXT, rndBit(), 1'b0, 1'b0);
        legal = (ity >= 4'd1) && (ity <= 4'd4) &&
                !((ity == 4'd1) && (fn != 6'h21) && (fn != 6'h23));
        if (!legal) begin
            for (int i = 0; i < 10; i++)
                pushStep(3'd5, TRAP, rndBit(), 1'b0, 1'b1);
        end else begin
            case (ity)
                4'd1: begin
                    pushStep(3'd2, SRC_A | ((fn == 6'h23) ? A_SUB : 16'h0), rndBit(), 1'b0, 1'b1);
                    pushStep(3'd4, REG_WE | REG_DST, rndBit(), 1'b1, 1'b1);
                end
                4'd2: begin
                    pushStep(3'd2, SRC_A | B_IMM | ((op == 6'h0F) ? A_LUI : A_OR), rndBit(), 1'b0, 1'b1);
                    pushStep(3'd4, REG_WE, rndBit(), 1'b1, 1'b1);
                end
                4'd3: begin
                    pushStep(3'd2, (az ? PC_WE : 16'h0) | PC_SRC | SRC_A | A_SUB, rndBit(), 1'b1, 1'b1);
                end
                default: begin
                    pushStep(3'd2, SRC_A | B_IMM | EXT, rndBit(), 1'b0, 1'b1);
                    for (int i = 0; i < mStall; i++)
                        pushStep(3'd3, MEM_RD | I_OR_D, 1'b0, 1'b0, 1'b1);
                    pushStep(3'd3, MEM_RD | I_OR_D, 1'b1, 1'b0, 1'b1);
                    pushStep(3'd4, REG_WE | M2R, rndBit(), 1'b1, 1'b1);
                end
            endcase
        end
    endtask

    // Plays the first 'limit' steps of the trace (all when limit is 0).
    // After DECODE the IR inputs are scrambled to prove the latches are used.
    task automatic applyStimulus(input logic [31:0] ins, input logic [3:0] ity,
                                 input logic az, input int limit);
        int n;
        n = (limit > 0 && limit < trace.size()) ? limit : trace.size();
        for (int i = 0; i < n; i++) begin
            step_t s;
            s = trace[i];
            if (s.scramble) begin
                bus.instr      = $urandom;
                bus.instr_type = 4'($urandom_range(0, 15));
            end else begin
                bus.instr      = ins;
                bus.instr_type = ity;
            end
            bus.mem_ready = s.mr;
            bus.alu_zero  = az;
            @(negedge clk);
            checkOutput($sformatf("i%08h_c%0d_state", ins, i), {29'd0, bus.state}, {29'd0, s.st});
            checkOutput($sformatf("i%08h_c%0d_ctl", ins, i), {16'd0, obsWord()}, {16'd0, s.word});
            checkOutput($sformatf("i%08h_c%0d_retired", ins, i), bus.retired, expRetired);
            @(posedge clk);
            #1;
            if (s.retire) expRetired++;
        end
    endtask

    task automatic runOne(input logic [31:0] ins, input logic [3:0] ity,
                          input logic az, input int fStall, input int mStall);
        buildTrace(ins, ity, az, fStall, mStall);
        applyStimulus(ins, ity, az, 0);
    endtask

    // Asynchronous reset: checked before any clock edge and across one edge
    task automatic applyReset();
        bus.mem_ready = 1'b1;
        reset = 1'b1;
        #1;
        checkOutput("rst_state", {29'd0, bus.state}, 32'd0);
        checkOutput("rst_retired", bus.retired, 32'd0);
        checkOutput("rst_enables", {28'd0, bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_rd}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_hold_state", {29'd0, bus.state}, 32'd0);
        checkOutput("rst_hold_enables", {28'd0, bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_rd}, 32'd0);
        checkOutput("rst_hold_trap", {31'd0, bus.trap}, 32'd0);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        expRetired = '0;
    endtask

    initial begin
        logic [31:0] ins;
        logic [3:0]  ity;
        bus.instr      = '0;
        bus.instr_type = '0;
        bus.mem_ready  = 1'b0;
        bus.alu_zero   = 1'b0;
        reset          = 1'b1;
        @(posedge clk);
        #1;
        applyReset();

        $display("[TB] directed instructions");
        runOne(32'h00221821, 4'd1, 1'b0, 0, 0);   // addu
        runOne(32'h8C220004, 4'd4, 1'b0, 0, 2);   // lw, two MEM stalls
        runOne(32'h10220003, 4'd3, 1'b1, 0, 0);   // beq taken
        runOne(32'h10220003, 4'd3, 1'b0, 0, 0);   // beq not taken
        runOne(32'h3C011234, 4'd2, 1'b0, 0, 0);   // lui
        runOne(32'h34210005, 4'd2, 1'b0, 1, 0);   // ori, one fetch stall

        $display("[TB] reset while stalled in MEM");
        buildTrace(32'h8C220004, 4'd4, 1'b0, 0, 4);
        applyStimulus(32'h8C220004, 4'd4, 1'b0, 5);
        checkOutput("pre_rst_state", {29'd0, bus.state}, 32'd3);
        applyReset();

        $display("[TB] illegal instructions");
        runOne(32'h08000000, 4'd0, 1'b0, 1, 0);   // j
        applyReset();
        runOne(32'h00221820, 4'd1, 1'b0, 0, 0);   // add (funct 0x20)
        applyReset();

        $display("[TB] random instructions");
        for (int k = 0; k < 150; k++) begin
            int r;
            r   = $urandom_range(0, 19);
            ins = $urandom;
            ity = (r == 0) ? 4'd0 : 4'($urandom_range(1, 4));
            case (ity)
                4'd1: begin
                    ins[31:26] = 6'h00;
                    r = $urandom_range(0, 5);
                    if (r < 2)      ins[5:0] = 6'h21;
                    else if (r < 4) ins[5:0] = 6'h23;
                end
                4'd2: ins[31:26] = rndBit() ? 6'h0F : 6'h0D;
                4'd3: ins[31:26] = 6'h04;
                4'd4: ins[31:26] = 6'h23;
                default: ;
            endcase
            runOne(ins, ity, rndBit(), $urandom_range(0, 3), $urandom_range(0, 3));
            if (trace[trace.size() - 1].st == 3'd5) applyReset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
